led_fade_pwm: RTL and testbench

Downstream stage of the 60-second color sequencer: consumes its 4-bit `color` code and drives the two bicolor LEDs (red1/blue1, red2/blue2) through PWM. Changes to the code are shown as a linear brightness ramp rather than a hard switch. Each of the four channels ramps its duty cycle independently toward its target and holds there until the code changes again.

---
 rtl/led_pkg.sv | 22 ++
 rtl/pwm_ramp_channel.sv | 46 ++++
 rtl/led_fade_pwm.sv | 113 +++++++++++
 tb/tb_led_fade_pwm.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED fade stage: colour codes, FSM states, decode helpers.
package led_pkg;

  localparam logic [1:0] CODE_OFF  = 2'b00;
  localparam logic [1:0] CODE_RED  = 2'b01;
  localparam logic [1:0] CODE_BLUE = 2'b10;
  localparam logic [1:0] CODE_BOTH = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_e;

  function automatic logic code_red(input logic [1:0] code);
    return (code == CODE_RED) || (code == CODE_BOTH);
  endfunction

  function automatic logic code_blue(input logic [1:0] code);
    return !((code == CODE_OFF) || (code == CODE_RED));
  endfunction

endpackage

// File: rtl/pwm_ramp_channel.sv
// One LED channel: duty register ramping one LSB per step toward 0 or full scale,
// plus the registered PWM compare driving the pin.
module pwm_ramp_channel #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_on,
  input  logic                i_step,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_eq_c,
  output logic                o_pin
);

  localparam logic [PWM_BITS-1:0] MAX_DUTY = '1;

  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] w_target;
  logic [PWM_BITS-1:0] w_duty_next;
  logic                r_pin;

  // Target is always an end stop, so a step toward it can never wrap.
  always_comb begin
    w_target    = i_on ? MAX_DUTY : '0;
    w_duty_next = r_duty;
    if (i_step && (r_duty != w_target)) begin
      w_duty_next = i_on ? (r_duty + PWM_BITS'(1)) : (r_duty - PWM_BITS'(1));
    end
  end

  // Equality is reported for the post-step duty so the FSM can leave FADE on the final step.
  assign o_eq_c = (w_duty_next == w_target);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty <= '0;
      r_pin  <= 1'b0;
    end else begin
      r_duty <= w_duty_next;
      r_pin  <= (r_duty == MAX_DUTY) | (i_pwm_cnt < r_duty);
    end
  end

  assign o_pin = r_pin;

endmodule

// File: rtl/led_fade_pwm.sv
// Bicolor LED driver: registers the sequencer colour code and fades four PWM
// channels linearly toward the decoded on/off targets.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned STEP_CYCLES = 125_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] color,
  output logic       red1,
  output logic       blue1,
  output logic       red2,
  output logic       blue2,
  output logic       busy
);

  localparam int unsigned        PRESC_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_CYCLES - 1);

  logic [3:0]          r_color_q;
  logic [3:0]          r_color_prev;
  logic [PRESC_W-1:0]  r_presc;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  state_e              r_state;
  state_e              w_next_state;
  logic                r_busy;
  logic                w_change;
  logic                w_step;
  logic                w_all_eq;
  logic [3:0]          w_on;
  logic [3:0]          w_eq;
  logic [3:0]          w_pin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_color_q    <= '0;
      r_color_prev <= '0;
    end else begin
      r_color_q    <= color;
      r_color_prev <= r_color_q;
    end
  end

  assign w_change = (r_color_q != r_color_prev);
  assign w_step   = (r_state == FADE) && (r_presc == PRESC_LAST);

  // Prescaler rests at 0 in IDLE and restarts on any code change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if ((r_state == IDLE) || w_change || w_step) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end
  end

  // Index map: 3 blue1, 2 red1, 1 blue2, 0 red2.
  assign w_on = {code_blue(r_color_q[3:2]), code_red(r_color_q[3:2]),
                 code_blue(r_color_q[1:0]), code_red(r_color_q[1:0])};

  for (genvar i = 0; i < 4; i++) begin : g_ch
    pwm_ramp_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_on     (w_on[i]),
      .i_step   (w_step),
      .i_pwm_cnt(r_pwm_cnt),
      .o_eq_c   (w_eq[i]),
      .o_pin    (w_pin[i])
    );
  end

  assign w_all_eq = &w_eq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == FADE);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!w_all_eq) w_next_state = FADE;
      FADE:    if (w_all_eq)  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign red1  = w_pin[2];
  assign blue1 = w_pin[3];
  assign red2  = w_pin[0];
  assign blue2 = w_pin[1];
  assign busy  = r_busy;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm with PWM_BITS=4, STEP_CYCLES=2.
module tb_led_fade_pwm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] color = 4'h0;
  logic       red1, blue1, red2, blue2, busy;

  int n_checks = 0;
  int n_errors = 0;
  int hi[5];
  int n;

  typedef struct {
    logic [3:0] code;
    logic [3:0] exp_pins;  // {red1, blue1, red2, blue2}
  } vec_t;

  vec_t vecs[11];

  led_fade_pwm #(
    .PWM_BITS   (4),
    .STEP_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .color(color),
    .red1 (red1),
    .blue1(blue1),
    .red2 (red2),
    .blue2(blue2),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Count high cycles of each output over n cycles; optionally toggle color[0] each cycle.
  task automatic observe(input int cycles, input bit toggle);
    for (int k = 0; k < 5; k++) hi[k] = 0;
    for (int c = 0; c < cycles; c++) begin
      if (toggle) color = color ^ 4'b0001;
      tick();
      hi[0] += int'(red1);
      hi[1] += int'(blue1);
      hi[2] += int'(red2);
      hi[3] += int'(blue2);
      hi[4] += int'(busy);
    end
  endtask

  // Count cycles until busy drops, tracking other-pin highs on the way.
  task automatic busy_len(input int bound, output int len, output int others);
    len    = 0;
    others = 0;
    while (busy && len < bound) begin
      tick();
      len++;
      others += int'(red2) + int'(blue2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len, others;
    vecs[0]  = '{4'h0, 4'b0000};
    vecs[1]  = '{4'h4, 4'b1000};
    vecs[2]  = '{4'hB, 4'b0111};
    vecs[3]  = '{4'hC, 4'b1100};
    vecs[4]  = '{4'h3, 4'b0011};
    vecs[5]  = '{4'hF, 4'b1111};
    vecs[6]  = '{4'h5, 4'b1010};
    vecs[7]  = '{4'hA, 4'b0101};
    vecs[8]  = '{4'h9, 4'b0110};
    vecs[9]  = '{4'h6, 4'b1001};
    vecs[10] = '{4'h0, 4'b0000};

    // Reset held
    repeat (3) tick();
    check("rst_pins", int'({red1, blue1, red2, blue2}), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    observe(50, 1'b0);
    check("idle_pins_high", hi[0] + hi[1] + hi[2] + hi[3], 0);
    check("idle_busy_high", hi[4], 0);

    // Fade up 0 -> 0100
    color = 4'h4;
    tick();
    check("up_busy_n1", int'(busy), 0);
    tick();
    check("up_busy_n2", int'(busy), 1);
    busy_len(100, len, others);
    check("up_busy_len", len, 30);
    check("up_other_pins", others, 0);
    observe(16, 1'b0);
    check("up_red1_full", hi[0], 16);
    check("up_blue1_off", hi[1], 0);

    // Mixed 0100 -> 1011
    color = 4'hB;
    tick();
    tick();
    check("mix_busy_rise", int'(busy), 1);
    busy_len(100, len, others);
    check("mix_busy_len", len, 30);
    observe(16, 1'b0);
    check("mix_red1", hi[0], 0);
    check("mix_blue1", hi[1], 16);
    check("mix_red2", hi[2], 16);
    check("mix_blue2", hi[3], 16);

    // Steady-state table
    for (int v = 0; v < 11; v++) begin
      color = vecs[v].code;
      repeat (40) tick();
      observe(16, 1'b0);
      for (int p = 0; p < 4; p++)
        check($sformatf("vec%0d_pin%0d", v, p), hi[p], vecs[v].exp_pins[3-p] ? 16 : 0);
      check($sformatf("vec%0d_busy", v), hi[4], 0);
    end

    // Code returns to original before any step: one busy cycle only
    color = 4'h4;
    tick();
    color = 4'h0;
    observe(10, 1'b0);
    check("bounce_busy_cycles", hi[4], 1);
    check("bounce_red1", hi[0], 0);

    // Retarget at duty 6 back to off
    color = 4'hC;
    repeat (14) tick();
    check("retgt_busy_before", int'(busy), 1);
    color = 4'h0;
    busy_len(100, len, others);
    check("retgt_busy_len", len, 12);
    observe(16, 1'b0);
    check("retgt_red1_off", hi[0] + hi[1], 0);

    // PWM shape: freeze red1 at duty 5 by retriggering the prescaler every cycle
    color = 4'h4;
    repeat (11) tick();
    observe(4, 1'b1);
    observe(16, 1'b1);
    check("pwm5_red1", hi[0], 5);
    check("pwm5_blue2", hi[3], 0);
    check("pwm5_busy", hi[4], 16);

    // Async reset mid-fade
    color = 4'h4;
    repeat (40) tick();
    check("pre_rst_red1", int'(red1), 1);
    color = 4'hF;
    repeat (5) tick();
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_pins", int'({red1, blue1, red2, blue2}), 0);
    check("async_rst_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!busy && n < 10) begin
      tick();
      n++;
    end
    check("post_rst_busy_rise", n, 2);
    busy_len(100, len, others);
    check("post_rst_ramp_len", len, 30);
    observe(16, 1'b0);
    check("post_rst_all_on", hi[0] + hi[1] + hi[2] + hi[3], 64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
